// File: rtl/ysyx_22040237_lsu.sv
`timescale 1ns/1ps
// Load/store unit: one op in flight, valid/ready memory request, aligned store lanes, load extension.
// Optional response timeout enabled by defining YSYX_22040237_LSU_TIMEOUT_EN.
module ysyx_22040237_lsu #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ls_valid_i,
  output logic        ls_ready_o,
  input  logic [6:0]  ls_info_bus_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  input  logic        rd_wr_en_i,
  input  logic [4:0]  rd_idx_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic        mem_req_wr_o,
  output logic [63:0] mem_req_addr_o,
  output logic [63:0] mem_req_wdata_o,
  output logic [7:0]  mem_req_wstrb_o,
  input  logic        mem_rsp_valid_i,
  input  logic [63:0] mem_rsp_rdata_i,
  input  logic        mem_rsp_err_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic        wb_rd_wr_en_o,
  output logic [4:0]  wb_rd_idx_o,
  output logic [63:0] wb_data_o,
  output logic [1:0]  wb_exc_o
);

  typedef enum logic [1:0] {StIdle, StReq, StRsp, StWb} state_e;

  state_e      state_q, state_d;
  logic [6:0]  info_q, info_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        rd_wr_en_q, rd_wr_en_d;
  logic [4:0]  rd_idx_q, rd_idx_d;
  logic [63:0] wb_data_q, wb_data_d;
  logic [1:0]  wb_exc_q, wb_exc_d;
  logic        wb_wr_q, wb_wr_d;
  logic        timeout;

  // Info bus layout: {dw, word, db, byte, usign, store, load}
  logic [3:0] in_size;
  logic       in_mem, in_illegal, in_misaligned;
  assign in_size    = ls_info_bus_i[6:3];
  assign in_mem     = ls_info_bus_i[0] | ls_info_bus_i[1];
  assign in_illegal = (ls_info_bus_i[0] & ls_info_bus_i[1]) |
                      !(in_size inside {4'b0001, 4'b0010, 4'b0100, 4'b1000});
  assign in_misaligned = (in_size[1] & addr_i[0]) | (in_size[2] & (|addr_i[1:0])) |
                         (in_size[3] & (|addr_i[2:0]));

  logic [2:0]  lane;
  logic [5:0]  lane_bits;
  logic [3:0]  size_q;
  logic [7:0]  strb_mask;
  logic [63:0] rsp_sh, load_ext;
  logic        sx;
  assign lane      = addr_q[2:0];
  assign lane_bits = {lane, 3'b000};
  assign size_q    = info_q[6:3];
  assign sx        = ~info_q[2];
  assign rsp_sh    = mem_rsp_rdata_i >> lane_bits;

  always_comb begin
    strb_mask = 8'h00;
    load_ext  = rsp_sh;
    case (size_q)
      4'b0001: begin
        strb_mask = 8'h01;
        load_ext  = {{56{sx & rsp_sh[7]}}, rsp_sh[7:0]};
      end
      4'b0010: begin
        strb_mask = 8'h03;
        load_ext  = {{48{sx & rsp_sh[15]}}, rsp_sh[15:0]};
      end
      4'b0100: begin
        strb_mask = 8'h0F;
        load_ext  = {{32{sx & rsp_sh[31]}}, rsp_sh[31:0]};
      end
      4'b1000: begin
        strb_mask = 8'hFF;
        load_ext  = rsp_sh;
      end
      default: ;
    endcase
  end

  logic req_act, req_st;
  assign req_act         = state_q == StReq;
  assign req_st          = req_act & info_q[1];
  assign ls_ready_o      = state_q == StIdle;
  assign mem_req_valid_o = req_act;
  assign mem_req_wr_o    = req_st;
  assign mem_req_addr_o  = req_act ? {addr_q[63:3], 3'b000} : 64'h0;
  assign mem_req_wdata_o = req_st ? (wdata_q << lane_bits) : 64'h0;
  assign mem_req_wstrb_o = req_st ? (strb_mask << lane) : 8'h00;
  assign wb_valid_o      = state_q == StWb;
  assign wb_rd_wr_en_o   = wb_wr_q;
  assign wb_rd_idx_o     = rd_idx_q;
  assign wb_data_o       = wb_data_q;
  assign wb_exc_o        = wb_exc_q;

`ifdef YSYX_22040237_LSU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] cnt_q;

  // Held at zero while requesting so the count starts fresh on entry to RSP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_q == StReq) begin
      cnt_q <= '0;
    end else if (state_q == StRsp) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end
  assign timeout = (state_q == StRsp) && (cnt_q == CntW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    info_d     = info_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_wr_en_d = rd_wr_en_q;
    rd_idx_d   = rd_idx_q;
    wb_data_d  = wb_data_q;
    wb_exc_d   = wb_exc_q;
    wb_wr_d    = wb_wr_q;
    case (state_q)
      StIdle: begin
        if (ls_valid_i) begin
          info_d     = ls_info_bus_i;
          addr_d     = addr_i;
          wdata_d    = wdata_i;
          rd_wr_en_d = rd_wr_en_i;
          rd_idx_d   = rd_idx_i;
          wb_data_d  = 64'h0;
          wb_exc_d   = 2'd0;
          wb_wr_d    = 1'b0;
          state_d    = StWb;
          if (!in_mem) begin
            wb_data_d = addr_i;
            wb_wr_d   = rd_wr_en_i;
          end else if (in_illegal) begin
            wb_exc_d = 2'd3;
          end else if (in_misaligned) begin
            wb_exc_d = 2'd1;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (mem_req_ready_i) state_d = StRsp;
      end
      StRsp: begin
        if (mem_rsp_valid_i) begin
          state_d = StWb;
          if (mem_rsp_err_i) begin
            wb_exc_d  = 2'd2;
            wb_data_d = 64'h0;
            wb_wr_d   = 1'b0;
          end else begin
            wb_exc_d  = 2'd0;
            wb_data_d = info_q[0] ? load_ext : 64'h0;
            wb_wr_d   = rd_wr_en_q & info_q[0];
          end
        end else if (timeout) begin
          state_d   = StWb;
          wb_exc_d  = 2'd2;
          wb_data_d = 64'h0;
          wb_wr_d   = 1'b0;
        end
      end
      StWb: begin
        if (wb_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      info_q     <= 7'h0;
      addr_q     <= 64'h0;
      wdata_q    <= 64'h0;
      rd_wr_en_q <= 1'b0;
      rd_idx_q   <= 5'h0;
      wb_data_q  <= 64'h0;
      wb_exc_q   <= 2'd0;
      wb_wr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      info_q     <= info_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_wr_en_q <= rd_wr_en_d;
      rd_idx_q   <= rd_idx_d;
      wb_data_q  <= wb_data_d;
      wb_exc_q   <= wb_exc_d;
      wb_wr_q    <= wb_wr_d;
    end
  end

endmodule
